// File: rtl/mips_pkg.sv
// mips_pkg: control-bundle type, NOP bundle and the PC / forwarding select encodings
package mips_pkg;
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_JMP = 2'b10;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
endpackage

// File: rtl/mips_hazard_unit.sv
// mips_hazard_unit: load-use stall, branch/jump redirect priority and EX forwarding selects
module mips_hazard_unit
    import mips_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_jump,
    input  logic             ex_mem_read,
    input  logic             ex_branch,
    input  logic             ex_zero,
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] mem_write_reg,
    input  logic             wb_reg_write,
    input  logic [REG_W-1:0] wb_write_reg,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic [1:0]       pc_sel,
    output logic             bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);
    logic stall, take, jmp;

    // EX/MEM is the younger producer, so it wins over MEM/WB
    function automatic logic [1:0] fwd(input logic [REG_W-1:0] src);
        return (mem_reg_write && mem_write_reg != '0 && mem_write_reg == src) ? FWD_EXMEM :
               (wb_reg_write && wb_write_reg != '0 && wb_write_reg == src)    ? FWD_MEMWB : FWD_RF;
    endfunction

    always_comb begin
        take       = ex_branch & ex_zero;
        stall      = ex_mem_read & (ex_rt != '0) & (ex_rt == id_rs | ex_rt == id_rt);
        jmp        = id_jump & ~stall & ~take;
        pc_write   = take | ~stall;
        ifid_write = take | ~stall;
        ifid_flush = take | jmp;
        pc_sel     = take ? PC_SEL_BR : jmp ? PC_SEL_JMP : PC_SEL_SEQ;
        bubble     = take | stall | jmp;
        fwd_a      = fwd(ex_rs);
        fwd_b      = fwd(ex_rt);
    end
endmodule

// File: rtl/mips_ctrl_pipe.sv
// mips_ctrl_pipe: carries decoded control bundles through ID/EX, EX/MEM and MEM/WB
module mips_ctrl_pipe
    import mips_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_dst,
    input  logic             id_alu_src,
    input  logic             id_mem_to_reg,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_branch,
    input  logic             id_jump,
    input  logic [1:0]       id_alu_op,
    input  logic             ex_zero,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic [1:0]       pc_sel,
    output logic             ex_alu_src,
    output logic [1:0]       ex_alu_op,
    output logic [REG_W-1:0] ex_rs,
    output logic [REG_W-1:0] ex_rt,
    output logic [REG_W-1:0] ex_write_reg,
    output logic             mem_mem_read,
    output logic             mem_mem_write,
    output logic [REG_W-1:0] mem_write_reg,
    output logic             wb_reg_write,
    output logic             wb_mem_to_reg,
    output logic [REG_W-1:0] wb_write_reg,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);
    typedef struct packed {
        ctrl_t            c;
        logic [REG_W-1:0] rs, rt, rd;
    } idex_t;

    typedef struct packed {
        logic             reg_write, mem_to_reg, mem_read, mem_write;
        logic [REG_W-1:0] wr;
    } exmem_t;

    typedef struct packed {
        logic             reg_write, mem_to_reg;
        logic [REG_W-1:0] wr;
    } memwb_t;

    idex_t  idex_q, idex_d;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;
    ctrl_t  id_c;
    logic   jump_s, bubble;

    // if-based capture turns an unknown strobe into 0; only datapath selects pass through
    always_comb begin
        id_c         = CTRL_NOP;
        id_c.reg_dst = id_reg_dst;
        id_c.alu_src = id_alu_src;
        id_c.alu_op  = id_alu_op;
        if (id_mem_to_reg) id_c.mem_to_reg = 1'b1;
        if (id_reg_write) id_c.reg_write = 1'b1;
        if (id_mem_read) id_c.mem_read = 1'b1;
        if (id_mem_write) id_c.mem_write = 1'b1;
        if (id_branch) id_c.branch = 1'b1;
        jump_s = 1'b0;
        if (id_jump && rst_n) jump_s = 1'b1;
    end

    mips_hazard_unit #(.REG_W(REG_W)) u_hazard (
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_jump       (jump_s),
        .ex_mem_read   (idex_q.c.mem_read),
        .ex_branch     (idex_q.c.branch),
        .ex_zero       (ex_zero),
        .ex_rs         (idex_q.rs),
        .ex_rt         (idex_q.rt),
        .mem_reg_write (exmem_q.reg_write),
        .mem_write_reg (exmem_q.wr),
        .wb_reg_write  (memwb_q.reg_write),
        .wb_write_reg  (memwb_q.wr),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .ifid_flush    (ifid_flush),
        .pc_sel        (pc_sel),
        .bubble        (bubble),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );

    assign ex_write_reg = idex_q.c.reg_dst ? idex_q.rd : idex_q.rt;

    always_comb begin
        idex_d = '0;
        if (!bubble) idex_d = {id_c, id_rs, id_rt, id_rd};
        exmem_d = {idex_q.c.reg_write, idex_q.c.mem_to_reg, idex_q.c.mem_read, idex_q.c.mem_write, ex_write_reg};
        memwb_d = {exmem_q.reg_write, exmem_q.mem_to_reg, exmem_q.wr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign ex_alu_src    = idex_q.c.alu_src;
    assign ex_alu_op     = idex_q.c.alu_op;
    assign ex_rs         = idex_q.rs;
    assign ex_rt         = idex_q.rt;
    assign mem_mem_read  = exmem_q.mem_read;
    assign mem_mem_write = exmem_q.mem_write;
    assign mem_write_reg = exmem_q.wr;
    assign wb_reg_write  = memwb_q.reg_write;
    assign wb_mem_to_reg = memwb_q.mem_to_reg;
    assign wb_write_reg  = memwb_q.wr;
endmodule

// File: tb/tb_mips_ctrl_pipe.sv
// tb_mips_ctrl_pipe: scoreboard bench against an instruction-level model of the control pipeline
module tb_mips_ctrl_pipe;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic id_reg_dst = 0, id_alu_src = 0, id_mem_to_reg = 0, id_reg_write = 0;
    logic id_mem_read = 0, id_mem_write = 0, id_branch = 0, id_jump = 0, ex_zero = 0;
    logic [1:0] id_alu_op = '0;
    logic pc_write, ifid_write, ifid_flush, ex_alu_src, mem_mem_read, mem_mem_write, wb_reg_write, wb_mem_to_reg;
    logic [1:0] pc_sel, ex_alu_op, fwd_a, fwd_b;
    logic [4:0] ex_rs, ex_rt, ex_write_reg, mem_write_reg, wb_write_reg;

    mips_ctrl_pipe #(.REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src), .id_mem_to_reg(id_mem_to_reg),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_branch(id_branch), .id_jump(id_jump), .id_alu_op(id_alu_op), .ex_zero(ex_zero),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush), .pc_sel(pc_sel),
        .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_write_reg(ex_write_reg), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_write_reg(mem_write_reg), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_write_reg(wb_write_reg), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    typedef struct {
        bit rw, m2r, mr, mw, br, src, dst, jmp;
        bit [1:0] op;
        bit [4:0] rs, rt, rd;
    } ins_t;
    typedef struct {
        logic [40:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    logic [40:0] act;
    int n_chk = 0, n_fail = 0;
    ins_t ex_m, mem_m, wb_m;

    function automatic ins_t nop();
        ins_t i = '{default: 0};
        return i;
    endfunction
    function automatic ins_t lw(bit [4:0] rs, bit [4:0] rt);
        ins_t i = nop();
        i.mr = 1; i.rw = 1; i.m2r = 1; i.src = 1; i.rs = rs; i.rt = rt;
        return i;
    endfunction
    function automatic ins_t sw(bit [4:0] rs, bit [4:0] rt);
        ins_t i = nop();
        i.mw = 1; i.src = 1; i.rs = rs; i.rt = rt;
        return i;
    endfunction
    function automatic ins_t rop(bit [4:0] rs, bit [4:0] rt, bit [4:0] rd);
        ins_t i = nop();
        i.rw = 1; i.dst = 1; i.op = 2'b10; i.rs = rs; i.rt = rt; i.rd = rd;
        return i;
    endfunction
    function automatic ins_t beq(bit [4:0] rs, bit [4:0] rt);
        ins_t i = nop();
        i.br = 1; i.op = 2'b01; i.rs = rs; i.rt = rt;
        return i;
    endfunction
    function automatic ins_t jmp_i();
        ins_t i = nop();
        i.jmp = 1;
        return i;
    endfunction

    function automatic bit [4:0] dest(ins_t i);
        return i.dst ? i.rd : i.rt;
    endfunction
    function automatic bit [1:0] fwd(bit [4:0] r);
        if (mem_m.rw && dest(mem_m) != 0 && dest(mem_m) == r) return 2'b10;
        if (wb_m.rw && dest(wb_m) != 0 && dest(wb_m) == r) return 2'b01;
        return 2'b00;
    endfunction

    // one cycle: drive ID inputs, predict every output for this cycle, then advance the model
    task automatic step(input ins_t id, input bit zero, input bit rst, input bit xc, input string tag);
        bit take, stall, jmp, was;
        bit [1:0] sel;
        @(posedge clk);
        #1;
        was = rst_n;
        rst_n = rst;
        id_rs = id.rs; id_rt = id.rt; id_rd = id.rd; id_reg_dst = id.dst; id_alu_src = id.src;
        id_mem_to_reg = id.m2r; id_reg_write = id.rw; id_mem_read = id.mr; id_mem_write = id.mw;
        id_branch = id.br; id_jump = id.jmp; id_alu_op = id.op; ex_zero = zero;
        if (xc) begin
            {id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write} = 'x;
            {id_mem_read, id_mem_write, id_branch, id_jump, id_alu_op} = 'x;
        end
        if (!rst) begin
            ex_m = nop(); mem_m = nop(); wb_m = nop();
        end
        take  = ex_m.br && zero;
        stall = ex_m.mr && ex_m.rt != 0 && (ex_m.rt == id.rs || ex_m.rt == id.rt);
        jmp   = rst && id.jmp && !stall && !take;
        sel   = take ? 2'b01 : jmp ? 2'b10 : 2'b00;
        sb.push_back('{{take || !stall, take || !stall, take || jmp, sel, ex_m.src, ex_m.op, ex_m.rs, ex_m.rt,
                        dest(ex_m), mem_m.mr, mem_m.mw, dest(mem_m), wb_m.rw, wb_m.m2r, dest(wb_m),
                        fwd(ex_m.rs), fwd(ex_m.rt)}, tag});
        if (was && !rst) begin
            #1;
            n_chk++;
            if (mem_mem_write !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_async: mem_mem_write=%b required 0", tag, mem_mem_write);
            end
        end
        if (rst) begin
            wb_m = mem_m;
            mem_m = ex_m;
            ex_m = (take || stall || jmp) ? nop() : id;
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            act = {pc_write, ifid_write, ifid_flush, pc_sel, ex_alu_src, ex_alu_op, ex_rs, ex_rt,
                   ex_write_reg, mem_mem_read, mem_mem_write, mem_write_reg, wb_reg_write, wb_mem_to_reg,
                   wb_write_reg, fwd_a, fwd_b};
            n_chk++;
            if (act !== cur.v) begin
                n_fail++;
                $display("FAIL %s: outputs %h required %h", cur.tag, act, cur.v);
            end
        end
    end

    function automatic ins_t rnd_ins();
        ins_t i;
        case ($urandom_range(0, 5))
            0: i = lw(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            1: i = sw(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            2: i = beq(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            3: i = jmp_i();
            4: i = nop();
            default: i = rop(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        endcase
        return i;
    endfunction

    initial begin
        ins_t t;
        for (int i = 0; i < 3; i++) step(nop(), 0, 0, 0, "rst_held");
        step(nop(), 0, 1, 0, "rst_release");
        step(lw(1, 8), 0, 1, 0, "lw");
        step(rop(8, 8, 9), 0, 1, 0, "lu_stall");
        step(rop(8, 8, 9), 0, 1, 0, "lu_bubble");
        step(nop(), 0, 1, 0, "lu_fwd01");
        step(rop(1, 2, 8), 0, 1, 0, "add8");
        step(rop(8, 3, 10), 0, 1, 0, "sub");
        step(nop(), 0, 1, 0, "fwd10");
        step(rop(1, 2, 0), 0, 1, 0, "add0");
        step(rop(0, 3, 10), 0, 1, 0, "sub0");
        step(nop(), 0, 1, 0, "fwd_r0");
        step(beq(1, 2), 0, 1, 0, "beq_id");
        step(rop(4, 5, 6), 1, 1, 0, "beq_taken");
        step(nop(), 0, 1, 0, "beq_bubble");
        step(beq(1, 2), 0, 1, 0, "beq_id2");
        step(rop(4, 5, 6), 0, 1, 0, "beq_not_taken");
        step(jmp_i(), 0, 1, 0, "j_id");
        step(nop(), 0, 1, 0, "j_bubble");
        step(beq(1, 2), 0, 1, 0, "beq_id3");
        step(jmp_i(), 1, 1, 0, "j_vs_beq");
        step(nop(), 0, 1, 0, "j_dropped");
        t = lw(0, 5);
        t.br = 1;
        step(t, 0, 1, 0, "lw_br");
        step(rop(5, 1, 2), 1, 1, 0, "stall_take");
        step(beq(3, 3), 0, 1, 0, "beq_id4");
        step(nop(), 1, 1, 1, "x_bubble");
        step(nop(), 0, 1, 0, "x_ex_zero");
        step(sw(1, 7), 0, 1, 0, "sw");
        step(nop(), 0, 1, 0, "sw_ex");
        step(nop(), 0, 1, 0, "sw_mem");
        step(nop(), 0, 0, 0, "rst_mid");
        step(nop(), 0, 0, 0, "rst_mid_held");
        step(nop(), 0, 1, 0, "rst_mid_release");
        for (int i = 0; i < 400; i++)
            step(rnd_ins(), 1'($urandom_range(0, 1)), $urandom_range(0, 79) != 0, 0, "random");
        @(negedge clk);
        #1;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_ctrl_pipe.md
# mips_ctrl_pipe

Carries decoded control bundles from the ID-stage main decoder through ID/EX, EX/MEM and MEM/WB, and is the single consumer of those bundles on the datapath side. It also owns:
- load-use stall detection;
- branch/jump redirect and flush;
- destination-register selection;
- EX-stage forwarding selects.

It sits between the opcode decoder and the five-stage datapath.

## Interface
Parameters:
- REG_W, 5, register-index width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_rs, id_rt, id_rd  in  REG_W  ID-stage register fields
- id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump  in  1 each  decoder outputs (may be X for don't-care)
- id_alu_op  in  2  decoder ALU op
- ex_zero  in  1  ALU zero flag of the EX instruction
- pc_write, ifid_write  out  1  PC / IF-ID enable
- ifid_flush  out  1  IF/ID cleared to NOP next edge
- pc_sel  out  2  00 PC+4, 01 branch target, 10 jump target
- ex_alu_src, ex_alu_op[1:0], ex_rs, ex_rt, ex_write_reg  out  ID/EX register contents
- mem_mem_read, mem_mem_write, mem_write_reg  out  EX/MEM contents
- wb_reg_write, wb_mem_to_reg, wb_write_reg  out  MEM/WB contents
- fwd_a, fwd_b  out  2  00 regfile, 10 from EX/MEM, 01 from MEM/WB

## Operation
**Load-use stall.**
- Condition: `stall = ex_mem_read & ex_rt != 0 & (ex_rt == id_rs | ex_rt == id_rt)`.
- Effect: pc_write = 0, ifid_write = 0, ID/EX loads a bubble.

**Branch taken.**
- Condition: `take = ex_branch & ex_zero`.
- Effect: pc_sel = 01, ifid_flush = 1, ID/EX loads a bubble.

**Jump.**
- Condition: `jmp = id_jump & ~stall & ~take`.
- Effect: pc_sel = 10, ifid_flush = 1. The jump's own bundle enters ID/EX as a bubble.

**Priority.**
- take > stall > jmp.
- When take is active, stall is ignored: pc_write = 1, ifid_write = 1.

**Bubble.** All control bits are 0, including reg_write, mem_read, mem_write and branch. X inputs therefore never propagate.
- When not bubbling, any X control bit is registered as 0.
- Only alu_op/alu_src/reg_dst don't-cares may pass through.

**Destination register.** `ex_write_reg = ex_reg_dst ? ex_rd : ex_rt`. It is computed in EX and registered forward into EX/MEM and MEM/WB.

**Forwarding (fwd_a).**
- 10 if `mem_reg_write & mem_write_reg != 0 & mem_write_reg == ex_rs`.
- Otherwise 01 if the same condition holds on the WB stage.
- Otherwise 00.
- EX/MEM has priority over MEM/WB.
- fwd_b uses the same rules on ex_rt.

**Register 0.** Register 0 never triggers a stall or a forward.

## Timing
- EX/MEM and MEM/WB advance every cycle and are never stalled.
- ID/EX loads every cycle, either the bundle or a bubble.
- Stall, flush, pc_sel and fwd are combinational from the current register state and ID inputs, and take effect on the next edge.
- Load-use costs exactly 1 bubble; the dependent instruction sees fwd = 01 in the following cycle.
- Taken branch costs 2 bubbles; jump costs 1.
- Reset: every pipeline register clears to 0 asynchronously. Outputs while reset is held and on the first cycle after release:
  - pc_write = 1, ifid_write = 1, ifid_flush = 0, pc_sel = 00;
  - fwd_a = fwd_b = 00;
  - all ex_/mem_/wb_ outputs 0.
- Reset asserted mid-operation drops all in-flight bundles. No write or memory strobe is issued afterwards.

## Structure
- Shared package `mips_pkg`:
  - ctrl bundle struct;
  - PC_SEL_{SEQ,BR,JMP} constants;
  - FWD_{RF,EXMEM,MEMWB} constants;
  - NOP bundle constant.
- One sub-module `mips_hazard_unit` (combinational: stall/take/jmp priority and fwd_a/fwd_b).
- The three stage registers live in the top module.

## Test plan
- Reset held 3 cycles, then released → all stage outputs 0, pc_write = 1, pc_sel = 00, fwd = 00. Reset asserted mid-stream with a sw in EX/MEM → mem_mem_write drops to 0 immediately.
- lw $8 then add $9,$8,$8 → one cycle with pc_write = 0, ifid_write = 0; bubble in EX (all 0); next cycle fwd_a = fwd_b = 01.
- add $8 followed directly by sub $10,$8,$3 → fwd_a = 10, fwd_b = 00. Same sequence with $0 as the destination → fwd = 00.
- beq in EX with ex_zero = 1 → pc_sel = 01, ifid_flush = 1, bubble in ID/EX. With ex_zero = 0 → no flush, pc_sel = 00.
- j in ID → pc_sel = 10, ifid_flush = 1, bubble in EX next cycle. j in ID while a taken beq is in EX → pc_sel = 01 and the jump is discarded.
- Stall and taken branch in the same cycle → pc_write = 1, pc_sel = 01, ifid_flush = 1. Decoder X bundle during a bubble → EX controls read 0, not X.
